// File: rtl/haar_row_synth_pkg.sv
// Shared types, widths and saturation helper for the inverse vertical Haar stage.
package haar_row_synth_pkg;

   localparam int unsigned LENGTH = 8;
   localparam int unsigned PIX_W  = 8;
   localparam int unsigned COEF_W = 9;
   localparam int unsigned ACC_W  = 10;

   typedef logic signed [COEF_W-1:0] coef_d_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic [PIX_W-1:0]         pix_t;

   typedef enum logic {EVEN = 1'b0, ODD = 1'b1} synth_state_t;

   typedef struct packed {
      pix_t pix;
      logic odd;
      logic last;
   } pix_beat_t;

   // Clamp a signed lifting result into the unsigned pixel range.
   function automatic pix_t sat8(input acc_t x);
      if (x[ACC_W-1]) return '0;
      if (|x[ACC_W-2:PIX_W]) return '1;
      return x[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/haar_row_synth_row_line_store.sv
// Simple dual-port line store: one write port, one registered read port, no reset on contents.
module row_line_store #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/haar_row_synth.sv
// Inverse vertical Haar stage: streams the even row as pairs arrive, then replays the parked odd row.
module haar_row_synth
   import haar_row_synth_pkg::*;
#(
   parameter int unsigned ROW_LEN = LENGTH
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       en,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_s,
   input  coef_d_t    in_d,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_pix,
   output logic       out_odd,
   output logic       out_last
);

   localparam int unsigned CW = $clog2(ROW_LEN);
   localparam logic [CW-1:0] LAST_COL = CW'(ROW_LEN - 1);

   synth_state_t state_q, state_d;
   logic [CW-1:0] col_q, col_d, rd_col_q, rd_col_d;
   logic          rd_vld_q, rd_vld_d, rd_done_q, rd_done_d;
   pix_beat_t     out_q, out_d;
   logic          out_valid_q, out_valid_d;

   acc_t s_x, d_x, half_v, even_v, odd_v;
   pix_t odd_pix, rd_data;
   logic free, hand_off, last_odd_ho, accept, load_odd, rd_issue;

   // Integer S-transform inverse lifting.
   always_comb begin
      s_x     = acc_t'(in_s);
      d_x     = acc_t'(in_d);
      half_v  = d_x >>> 1;
      even_v  = s_x - half_v;
      odd_v   = d_x + even_v;
      odd_pix = sat8(odd_v);
   end

   assign free        = !out_valid_q || out_ready;
   assign hand_off    = out_valid_q && out_ready && en;
   assign last_odd_ho = (state_q == ODD) && out_valid_q && out_ready && out_q.odd && out_q.last;
   assign in_ready    = (state_q == EVEN) ? free : last_odd_ho;
   assign accept      = in_valid && in_ready && en;
   assign load_odd    = (state_q == ODD) && rd_vld_q && free && en;
   // A read only issues when its data can move into the output register next cycle.
   assign rd_issue    = (state_q == ODD) && !rd_done_q && free && (!rd_vld_q || load_odd) && en;

   row_line_store #(
      .DEPTH(ROW_LEN),
      .WIDTH(PIX_W),
      .AW   (CW)
   ) u_store (
      .clk    (clk),
      .we_i   (accept),
      .waddr_i(col_q),
      .wdata_i(odd_pix),
      .re_i   (rd_issue),
      .raddr_i(col_q),
      .rdata_o(rd_data)
   );

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      rd_col_d    = rd_col_q;
      rd_vld_d    = rd_vld_q;
      rd_done_d   = rd_done_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;

      if (hand_off) out_valid_d = 1'b0;

      if (load_odd) begin
         out_d       = '{pix: rd_data, odd: 1'b1, last: (rd_col_q == LAST_COL)};
         out_valid_d = 1'b1;
         rd_vld_d    = 1'b0;
      end

      if (rd_issue) begin
         rd_col_d = col_q;
         rd_vld_d = 1'b1;
         if (col_q == LAST_COL) begin
            col_d     = '0;
            rd_done_d = 1'b1;
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      if (last_odd_ho && en) begin
         state_d   = EVEN;
         rd_done_d = 1'b0;
      end

      // An accept may coincide with the final odd hand-off; it then starts the next pair.
      if (accept) begin
         out_d       = '{pix: sat8(even_v), odd: 1'b0, last: (col_q == LAST_COL)};
         out_valid_d = 1'b1;
         if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = ODD;
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= EVEN;
         col_q       <= '0;
         rd_col_q    <= '0;
         rd_vld_q    <= 1'b0;
         rd_done_q   <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         rd_col_q    <= rd_col_d;
         rd_vld_q    <= rd_vld_d;
         rd_done_q   <= rd_done_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pix   = out_q.pix;
   assign out_odd   = out_q.odd;
   assign out_last  = out_q.last;

endmodule
